fp16_to_int: RTL and testbench
==============================

Name: fp16_to_int

Overview:
- Multi-cycle converter that unpacks an IEEE-754 binary16 value into a signed two's-complement integer of width INT_W.
- Decode-side counterpart of the fp16 adder/packer: it classifies special operands (zero, subnormal, inf, NaN), denormalises the significand with a serial shifter and saturates out-of-range values.
- Sits at the output of the fp16 MAC datapath, feeding integer consumers through valid/ready handshakes on both sides.

Parameters:
- INT_W, 16, result width in bits; legal range 12..32.

Ports:
- CLK  input  1  clock, rising edge.
- RESETn  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  converter can accept; high only in IDLE.
- in_data  input  16  fp16 operand: sign [15], exponent [14:10], mantissa [9:0].
- out_valid  output  1  result is valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- out_data  output  INT_W  signed integer result.
- out_flags  output  4  {nan, inf, ovf, inexact}.

Behaviour:
- Reset (async, any state, including mid-conversion): state=IDLE; out_valid=0; out_data=0; out_flags=0; internal registers cleared. in_ready=1 once RESETn deasserts.
- FSM states: IDLE, CLASS, SHIFT, ROUND, DONE.
- IDLE: in_ready=1. When in_valid=1 at an edge, latch in_data and go to CLASS.
- CLASS (1 cycle): let e = exp-15 and k = |e-10|.
  - exp=31, mant!=0: out_data=0, nan=1, go to DONE.
  - exp=31, mant=0: out_data = sign ? -2^(INT_W-1) : 2^(INT_W-1)-1, inf=1, go to DONE.
  - exp=0: out_data=0; inexact = (mant!=0); go to DONE.
  - Normal with e<0: out_data=0, inexact=1, go to DONE. Exception: e=-1 takes the in-range path when the optional feature is enabled.
  - Normal with e>INT_W-2: saturate as for inf, ovf=1, go to DONE. Exception: sign=1, e=INT_W-1, mant=0 gives out_data=-2^(INT_W-1) with flags 0.
  - Normal in range: load mag = {1, mant} zero-extended to INT_W+1 bits; clear guard and sticky. Direction is left if e>=10, right if e<10. Load the shift counter with k. Go to SHIFT if k>0, otherwise ROUND.
- SHIFT: one bit position per cycle; counter decrements.
  - Right shift: the bit shifted out of mag becomes guard; the previous guard ORs into sticky.
  - Go to ROUND on the cycle the counter reaches 0.
- ROUND (1 cycle):
  - inexact = guard | sticky.
  - Truncation (round toward zero) by default.
  - Magnitude reaching 2^(INT_W-1) after rounding: positive saturates to max with ovf=1; negative yields -2^(INT_W-1), exact.
  - Apply sign by two's complement. Go to DONE.
- DONE: out_valid=1; out_data and out_flags stable. On out_valid & out_ready, go to IDLE and drop out_valid.
- No new input is accepted while busy; no bypass from DONE to CLASS. Back-to-back throughput is therefore latency+1.
- Latency, from the accept edge to out_valid high:
  - 1 cycle for specials, zero, subnormal, underflow and saturation.
  - k+2 cycles for in-range normals.
- Flags are mutually exclusive except inexact, which is set only in finite in-range, subnormal and underflow cases.

Optional Feature:
- Macro FP16_TO_INT_RNE_EN.
- Defined:
  - ROUND increments the magnitude when guard & (sticky | lsb), i.e. round-to-nearest-even.
  - e=-1 (0.5 <= |x| < 1) takes the in-range path with k=11.
  - inexact semantics unchanged.
- Undefined: truncation toward zero as above; rounding increment logic absent.

Test Plan:
- 0x4900 (10.0), out_ready=1 -> out_data=0x000A, flags=0000, out_valid 9 cycles after accept (k=7).
- 0xC5A0 (-5.625) -> 0xFFFB, flags=0001. With FP16_TO_INT_RNE_EN: 0xFFFA, flags=0001.
- Specials, one at a time:
  - 0x7C00 -> 0x7FFF, flags=0100.
  - 0x7E00 -> 0x0000, flags=1000.
  - 0xF800 -> 0x8000, flags=0000.
  - 0x7800 -> 0x7FFF, flags=0010.
  - Each with out_valid 1 cycle after accept.
- Small values:
  - 0x3800 (0.5) -> 0x0000, flags=0001 with and without the macro (tie-to-even).
  - 0x3A00 (0.75) -> 0x0000 without the macro, 0x0001 with it.
  - 0x0001 (subnormal) -> 0x0000, flags=0001.
- Backpressure: 0x4900 with out_ready=0 for 5 cycles after out_valid -> out_data stays 0x000A, in_ready=0 throughout; in_ready=1 the cycle after out_ready=1.
- Reset during SHIFT of 0x4900: RESETn low 2 cycles -> out_valid, out_data, out_flags read 0 immediately. Next input 0x3C00 then converts to 0x0001, flags=0000.

Source files
------------

// File: rtl/fp16_to_int.sv
// fp16_to_int: multi-cycle fp16 to signed INT_W converter with a serial denormalising shifter.
// Define FP16_TO_INT_RNE_EN for round-to-nearest-even; the default build truncates toward zero.
module fp16_to_int #(
  parameter int INT_W = 16
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_data,
  output logic [3:0]       out_flags
);
  typedef enum logic [2:0] {IDLE, CLASS, SHIFT, ROUND, DONE} state_t;
  localparam logic [INT_W-1:0] MAXV = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MINV = {1'b1, {(INT_W-1){1'b0}}};
`ifdef FP16_TO_INT_RNE_EN
  localparam int LO = -1;
`else
  localparam int LO = 0;
`endif
  state_t state, state_nx;
  logic [15:0] op;
  logic [INT_W:0] mag, mag_r;
  logic guard, sticky, left, inc, sat;
  logic [4:0] cnt, k;
  logic sign, spec, sub, under, over, min_exact, in_range;
  logic [4:0] expo;
  logic [9:0] mant;
  int e;
  logic [INT_W-1:0] c_data, r_data;
  logic [3:0] c_flags, r_flags;
  assign sign = op[15];
  assign expo = op[14:10];
  assign mant = op[9:0];
  assign e = int'(expo) - 15;
  assign k = 5'(e >= 10 ? e - 10 : 10 - e);
  assign spec = expo == 5'd31;
  assign sub = expo == 5'd0;
  assign under = !spec && !sub && e < LO;
  assign min_exact = !spec && sign && e == INT_W - 1 && mant == 10'd0;
  assign over = !spec && !min_exact && e > INT_W - 2;
  assign in_range = !spec && !sub && !under && !over && !min_exact;
  assign c_data = (spec && mant == 10'd0) || over || min_exact ? (sign ? MINV : MAXV) : '0;
  assign c_flags = {spec && mant != 10'd0, spec && mant == 10'd0, over, (sub && mant != 10'd0) || under};
`ifdef FP16_TO_INT_RNE_EN
  assign inc = guard & (sticky | mag[0]);
`else
  assign inc = 1'b0;
`endif
  assign mag_r = mag + {{INT_W{1'b0}}, inc};
  assign sat = mag_r[INT_W] | mag_r[INT_W-1];
  assign r_data = sat ? (sign ? MINV : MAXV) : (sign ? -mag_r[INT_W-1:0] : mag_r[INT_W-1:0]);
  assign r_flags = sat ? {2'b00, !sign, 1'b0} : {3'b000, guard | sticky};
  assign in_ready = RESETn && state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? CLASS : IDLE;
      CLASS:   state_nx = !in_range ? DONE : (k != 5'd0 ? SHIFT : ROUND);
      SHIFT:   state_nx = cnt == 5'd1 ? ROUND : SHIFT;
      ROUND:   state_nx = DONE;
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      op <= '0;
      mag <= '0;
      guard <= 1'b0;
      sticky <= 1'b0;
      left <= 1'b0;
      cnt <= '0;
      out_data <= '0;
      out_flags <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) op <= in_data;
        CLASS: begin
          out_data <= c_data;
          out_flags <= c_flags;
          mag <= (INT_W+1)'({1'b1, mant});
          guard <= 1'b0;
          sticky <= 1'b0;
          left <= e >= 10;
          cnt <= k;
        end
        SHIFT: begin
          cnt <= cnt - 5'd1;
          mag <= left ? mag << 1 : mag >> 1;
          if (!left) begin
            guard <= mag[0];
            sticky <= sticky | guard;
          end
        end
        ROUND: begin
          out_data <= r_data;
          out_flags <= r_flags;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_fp16_to_int.sv
// tb_fp16_to_int: directed vectors with a scoreboard queue checked by a separate output monitor.
module tb_fp16_to_int;
  logic CLK = 1'b0, RESETn = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] in_data = '0;
  logic in_ready, out_valid;
  logic [15:0] out_data;
  logic [3:0] out_flags;
  int tests = 0, fails = 0, cyc = 0;
  typedef struct {logic [15:0] d; logic [3:0] f; int at;} exp_t;
  exp_t q[$];
  logic prev_v = 1'b0;

  fp16_to_int #(.INT_W(16)) dut (
    .CLK(CLK), .RESETn(RESETn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags)
  );

  always #5 CLK = ~CLK;
  always_ff @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (out_valid && !prev_v) begin
      if (q.size() == 0) chk("unexpected out_valid", 1, 0);
      else begin
        exp_t x;
        x = q.pop_front();
        chk($sformatf("data[%h]", x.d), 32'(out_data), 32'(x.d));
        chk($sformatf("flags[%h]", x.d), 32'(out_flags), 32'(x.f));
        chk($sformatf("latency[%h]", x.d), 32'(cyc), 32'(x.at));
      end
    end
    prev_v = out_valid;
  end

  task automatic issue(input logic [15:0] din, input logic [15:0] d, input logic [3:0] f,
                       input int lat, input bit push);
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge CLK); n++; end
    chk("in_ready timeout", 32'(in_ready), 1);
    @(negedge CLK);
    in_valid = 1'b1;
    in_data = din;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    if (push) q.push_back('{d, f, cyc + lat});
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 200) begin @(negedge CLK); n++; end
    if (n >= 200) chk("completion timeout", 0, 1);
  endtask

  task automatic send(input logic [15:0] din, input logic [15:0] d, input logic [3:0] f, input int lat);
    issue(din, d, f, lat, 1'b1);
    wait_idle();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_data", 32'(out_data), 0);
    chk("reset out_flags", 32'(out_flags), 0);
    RESETn = 1'b1;
    #1;
    chk("in_ready after reset", 32'(in_ready), 1);
    send(16'h4900, 16'h000A, 4'b0000, 9);
    send(16'h7C00, 16'h7FFF, 4'b0100, 1);
    send(16'h7E00, 16'h0000, 4'b1000, 1);
    send(16'hF800, 16'h8000, 4'b0000, 1);
    send(16'h7800, 16'h7FFF, 4'b0010, 1);
    send(16'hFC00, 16'h8000, 4'b0100, 1);
    send(16'h7BFF, 16'h7FFF, 4'b0010, 1);
    send(16'h0001, 16'h0000, 4'b0001, 1);
    send(16'h8001, 16'h0000, 4'b0001, 1);
    send(16'h0000, 16'h0000, 4'b0000, 1);
    send(16'h5640, 16'h0064, 4'b0000, 6);
    send(16'hD640, 16'hFF9C, 4'b0000, 6);
    send(16'h77FF, 16'h7FF0, 4'b0000, 6);
    send(16'hF7FF, 16'h8010, 4'b0000, 6);
    send(16'h4100, 16'h0002, 4'b0001, 11);
`ifdef FP16_TO_INT_RNE_EN
    send(16'hC5A0, 16'hFFFA, 4'b0001, 10);
    send(16'h3800, 16'h0000, 4'b0001, 13);
    send(16'h3A00, 16'h0001, 4'b0001, 13);
    send(16'h3E00, 16'h0002, 4'b0001, 12);
`else
    send(16'hC5A0, 16'hFFFB, 4'b0001, 10);
    send(16'h3800, 16'h0000, 4'b0001, 1);
    send(16'h3A00, 16'h0000, 4'b0001, 1);
    send(16'h3E00, 16'h0001, 4'b0001, 12);
`endif
    out_ready = 1'b0;
    issue(16'h4900, 16'h000A, 4'b0000, 9, 1'b1);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin @(negedge CLK); n++; end
      chk("bp out_valid timeout", 32'(out_valid), 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bp out_valid held", 32'(out_valid), 1);
      chk("bp out_data held", 32'(out_data), 32'h000A);
      chk("bp in_ready low", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    chk("bp in_ready after accept", 32'(in_ready), 1);
    chk("bp out_valid dropped", 32'(out_valid), 0);
    wait_idle();
    issue(16'h4900, 16'h000A, 4'b0000, 9, 1'b0);
    repeat (3) @(posedge CLK);
    #2;
    RESETn = 1'b0;
    #1;
    chk("mid-shift reset out_valid", 32'(out_valid), 0);
    chk("mid-shift reset out_data", 32'(out_data), 0);
    chk("mid-shift reset out_flags", 32'(out_flags), 0);
    @(negedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;
    #1;
    chk("in_ready after mid reset", 32'(in_ready), 1);
    send(16'h3C00, 16'h0001, 4'b0000, 12);
    repeat (5) @(negedge CLK);
    chk("scoreboard drained", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
